// File: rtl/ball_layer_gen.sv
// ball_layer_gen: 3-stage ball sprite overlay; define BALL_OUTLINE_EN to draw ball rims in inverted colour
module ball_layer_gen #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W = 10,
  parameter int COLOR_W = 10
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Frame_Start,
  input  logic                           Pix_Valid,
  input  logic [COORD_W-1:0]             VGA_X,
  input  logic [COORD_W-1:0]             VGA_Y,
  input  logic [NUM_BALLS*COORD_W-1:0]   Ball_X,
  input  logic [NUM_BALLS*COORD_W-1:0]   Ball_Y,
  input  logic [NUM_BALLS*COORD_W-1:0]   Ball_S,
  input  logic [NUM_BALLS*3*COLOR_W-1:0] Ball_RGB,
  input  logic [NUM_BALLS-1:0]           Ball_En,
  input  logic [3*COLOR_W-1:0]           Bg_RGB,
  output logic [COLOR_W-1:0]             VGA_R,
  output logic [COLOR_W-1:0]             VGA_G,
  output logic [COLOR_W-1:0]             VGA_B,
  output logic                           Out_Valid,
  output logic [NUM_BALLS-1:0]           Hit_Mask
);
  localparam int CW = COORD_W;
  localparam int PW = 2 * COORD_W;
  localparam int DW = 2 * COORD_W + 1;
  localparam int RW = 3 * COLOR_W;
  logic [NUM_BALLS*CW-1:0] sh_x, sh_y, sh_s;
  logic [NUM_BALLS*RW-1:0] sh_rgb;
  logic [NUM_BALLS-1:0]    sh_en;
  logic                           v1, v2;
  logic [NUM_BALLS-1:0][CW-1:0]   dx_c, dy_c, dx1, dy1, s1;
  logic [NUM_BALLS-1:0][RW-1:0]   rgb1, rgb2;
  logic [NUM_BALLS-1:0]           en1, en2, hit, inv;
  logic [NUM_BALLS-1:0][DW-1:0]   d2_c, d2;
  logic [NUM_BALLS-1:0][PW-1:0]   r2_c, r2;
  logic [RW-1:0]                  col;
`ifdef BALL_OUTLINE_EN
  logic [NUM_BALLS-1:0][PW-1:0]   rm_c, rm2;
  logic [NUM_BALLS-1:0]           nz_c, nz2;
`endif
  // Every ball attribute travels with its pixel so a mid-pipeline reload never mixes frames
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh_x <= '0;
      sh_y <= '0;
      sh_s <= '0;
      sh_rgb <= '0;
      sh_en <= '0;
    end else if (Frame_Start) begin
      sh_x <= Ball_X;
      sh_y <= Ball_Y;
      sh_s <= Ball_S;
      sh_rgb <= Ball_RGB;
      sh_en <= Ball_En;
    end
  end
  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_b
    logic [CW:0] ex, ey;
    assign ex = {1'b0, VGA_X} - {1'b0, sh_x[g*CW +: CW]};
    assign ey = {1'b0, VGA_Y} - {1'b0, sh_y[g*CW +: CW]};
    assign dx_c[g] = CW'(ex[CW] ? -ex : ex);
    assign dy_c[g] = CW'(ey[CW] ? -ey : ey);
    assign d2_c[g] = {1'b0, PW'(dx1[g]) * PW'(dx1[g])} + {1'b0, PW'(dy1[g]) * PW'(dy1[g])};
    assign r2_c[g] = PW'(s1[g]) * PW'(s1[g]);
    assign hit[g] = en2[g] & (d2[g] <= {1'b0, r2[g]});
`ifdef BALL_OUTLINE_EN
    logic [CW-1:0] sm;
    assign sm = s1[g] - CW'(1);
    assign rm_c[g] = PW'(sm) * PW'(sm);
    assign nz_c[g] = |s1[g];
    assign inv[g] = nz2[g] & (d2[g] > {1'b0, rm2[g]});
`else
    assign inv[g] = 1'b0;
`endif
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1 <= 1'b0;
      dx1 <= '0;
      dy1 <= '0;
      s1 <= '0;
      en1 <= '0;
      rgb1 <= '0;
      v2 <= 1'b0;
      d2 <= '0;
      r2 <= '0;
      en2 <= '0;
      rgb2 <= '0;
`ifdef BALL_OUTLINE_EN
      rm2 <= '0;
      nz2 <= '0;
`endif
    end else begin
      v1 <= Pix_Valid;
      dx1 <= dx_c;
      dy1 <= dy_c;
      s1 <= sh_s;
      en1 <= sh_en;
      rgb1 <= sh_rgb;
      v2 <= v1;
      d2 <= d2_c;
      r2 <= r2_c;
      en2 <= en1;
      rgb2 <= rgb1;
`ifdef BALL_OUTLINE_EN
      rm2 <= rm_c;
      nz2 <= nz_c;
`endif
    end
  end
  // Walk from the top index down so the lowest-index hit wins
  always_comb begin
    col = Bg_RGB;
    for (int i = NUM_BALLS - 1; i >= 0; i--)
      col = hit[i] ? rgb2[i] ^ {RW{inv[i]}} : col;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      Out_Valid <= 1'b0;
      Hit_Mask <= '0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= v2 ? col : '0;
      Out_Valid <= v2;
      Hit_Mask <= v2 ? hit : '0;
    end
  end
endmodule

// File: doc/ball_layer_gen.md
BALL_LAYER_GEN -- requirements
Module: ball_layer_gen

Parameters
- NUM_BALLS, default 4: number of ball channels, 1..8.
- COORD_W, default 10: coordinate and size width in bits.
- COLOR_W, default 10: width of each colour component.

Interface
- REQ-001 SHALL: Clk  in  1  — single clock; all logic rising-edge.
- REQ-002 SHALL: Reset  in  1  — synchronous, active-high reset.
- REQ-003 SHALL: Frame_Start  in  1  — one-cycle pulse, issued during vertical blanking; loads the ball shadow registers.
- REQ-004 SHALL: Pix_Valid  in  1  — current VGA_X/VGA_Y is an active pixel.
- REQ-005 SHALL: VGA_X, VGA_Y  in  COORD_W each  — scan coordinate.
- REQ-006 SHALL: Ball_X, Ball_Y, Ball_S  in  NUM_BALLS*COORD_W each  — packed per-ball centre and radius; ball i occupies bits [i*COORD_W +: COORD_W].
- REQ-007 SHALL: Ball_RGB  in  NUM_BALLS*3*COLOR_W  — packed per-ball colour, ordered {R,G,B} per ball.
- REQ-008 SHALL: Ball_En  in  NUM_BALLS  — per-ball enable.
- REQ-009 SHALL: Bg_RGB  in  3*COLOR_W  — background colour, {R,G,B}; sampled live, not shadowed.
- REQ-010 SHALL: VGA_R, VGA_G, VGA_B  out  COLOR_W each  — registered pixel colour.
- REQ-011 SHALL: Out_Valid  out  1  — Pix_Valid delayed to align with the colour outputs.
- REQ-012 SHALL: Hit_Mask  out  NUM_BALLS  — registered; bit i set when the output pixel is inside ball i (all enabled balls, before priority).

Function
- REQ-013 SHALL: On a cycle with Frame_Start=1, load Ball_X/Y/S/RGB/En into shadow registers at the clock edge. Stage 1 SHALL use only shadow values, so new values affect pixels entered from the next cycle onward. Mid-frame input changes without Frame_Start SHALL have no effect.
- REQ-014 SHALL: 3-stage pipeline, latency exactly 3 cycles from pixel input to VGA_R/G/B, Out_Valid and Hit_Mask. Throughput is 1 pixel per cycle, with no stalls.
- REQ-015 SHALL: Stage 1 computes, per ball, dx=|VGA_X−Ball_X| and dy=|VGA_Y−Ball_Y| using COORD_W+1-bit signed subtraction. Results are COORD_W bits; modular wrap is not allowed.
- REQ-016 SHALL: Stage 2 computes D2=dx²+dy² at 2*COORD_W+1 bits and R2=S² at 2*COORD_W bits, with no truncation.
- REQ-017 SHALL: Stage 3 sets hit_i = Ball_En_i AND (D2 ≤ R2).
- REQ-018 SHALL: Priority: the lowest-index hit ball supplies the colour; with no hit, Bg_RGB is used.
- REQ-019 SHALL: When the pipelined Pix_Valid is 0 at stage 3, VGA_R/G/B=0, Hit_Mask=0 and Out_Valid=0 (blanking).
- REQ-020 SHALL: Ball_S=0 gives a hit only at the exact centre pixel. A disabled ball never hits, regardless of geometry.
- REQ-021 SHALL: Frame_Start coincident with Pix_Valid=1 is legal; that pixel uses the old shadow values.

Reset
- REQ-022 SHALL: While Reset=1, at each edge, clear all pipeline registers, VGA_R/G/B, Out_Valid and Hit_Mask to 0, and clear all shadow registers to 0 (all balls disabled).
- REQ-023 SHALL: Reset overrides a simultaneous Frame_Start.
- REQ-024 SHALL: After Reset deasserts, Out_Valid stays 0 until valid pixels have propagated 3 stages; in-flight pixels are discarded.

Configuration
- REQ-025 SHALL: Macro BALL_OUTLINE_EN.
  - Defined: for a hit ball with S≥1 and D2 > (S−1)², the pixel colour is the bitwise inverse of that ball's Ball_RGB; the extra compare stays within the 3-cycle latency.
  - Undefined: hit pixels always use Ball_RGB; no (S−1)² logic is generated.

Verification (NUM_BALLS=2, COORD_W=COLOR_W=10, BALL_OUTLINE_EN undefined unless stated)
- REQ-026 SHALL: Ball0 (100,100) S=10, enabled, loaded by Frame_Start. Pixel (110,100) → ball0 colour, Hit_Mask=01, 3 cycles later. Pixel (111,100) → Bg_RGB, Hit_Mask=00.
- REQ-027 SHALL: Ball0 and ball1 both at (200,200) S=5 with different colours. Pixel (200,200) → ball0 colour, Hit_Mask=11. With Ball_En=10 latched → ball1 colour, Hit_Mask=10.
- REQ-028 SHALL: Ball0 (0,0) S=5. Pixel (639,0) → background; pixel (3,4) → hit, since 9+16=25 ≤ 25.
- REQ-029 SHALL: Change Ball_X from 100 to 300 mid-frame without Frame_Start → pixel (100,100) still hits. After the next Frame_Start, pixel (300,100) hits and pixel (100,100) does not.
- REQ-030 SHALL: Assert Reset with 3 valid pixels in flight → outputs 0 at the next edge, no Out_Valid pulses from those pixels, and all balls disabled until the next Frame_Start.
- REQ-031 SHALL: With BALL_OUTLINE_EN defined, ball0 (100,100) S=10, colour 0x3FF/0/0:
  - pixel (110,100) → R=0, G=B=0x3FF (outline);
  - pixel (105,100) → R=0x3FF, G=B=0 (fill).
